// File: rtl/irq_controller_pkg.sv
//==============================================================================
// Module      : irq_controller_pkg
// Description : Shared register offsets, FSM encoding and line count for the
//               interrupt controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package irq_controller_pkg;

    localparam int c_num_lines = 4;
    localparam int c_id_w      = 2;

    localparam logic [1:0] c_off_mask    = 2'd0;
    localparam logic [1:0] c_off_pending = 2'd1;
    localparam logic [1:0] c_off_cause   = 2'd2;
    localparam logic [1:0] c_off_eoi     = 2'd3;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_fire    = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

endpackage

`default_nettype wire

// File: rtl/irq_prio_sel.sv
//==============================================================================
// Module      : irq_prio_sel
// Description : Rotating request selector; search starts at (last id + 1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_prio_sel
    import irq_controller_pkg::*;
(
    input  logic [c_num_lines-1:0] i_req,
    input  logic [c_id_w-1:0]      i_last_id,
    output logic                   o_valid,
    output logic [c_id_w-1:0]      o_id
);

    logic [c_id_w-1:0] w_idx;

    // Scanned from lowest to highest priority so the last hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        w_idx   = '0;
        for (int k = c_num_lines; k >= 1; k--) begin
            w_idx = i_last_id + k[c_id_w-1:0];
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_id    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
//==============================================================================
// Module      : irq_controller
// Description : 4-line edge-triggered interrupt controller with a memory-mapped
//               register window. Define IRQC_ROUND_ROBIN_EN for round-robin
//               arbitration; otherwise fixed priority (line 0 highest).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_controller
    import irq_controller_pkg::*;
#(
    parameter logic [7:0] BASE = 8'hF8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_in,
    input  logic       rw,
    input  logic [7:0] usermem_address,
    input  logic [7:0] usermem_data_out,
    input  logic       pc_freeze,
    output logic       interrupt,
    output logic       irqc_hit,
    output logic [7:0] irqc_rdata
);

    logic [7:0]             r_mask;
    logic [c_num_lines-1:0] r_pending;
    logic [c_num_lines-1:0] r_irq_prev;
    logic [1:0]             r_state;
    logic                   r_in_service;
    logic [c_id_w-1:0]      r_cause_id;
    logic [c_id_w-1:0]      r_sel_id;

    logic [7:0]             w_off;
    logic                   w_wr;
    logic [c_num_lines-1:0] w_rise;
    logic [c_num_lines-1:0] w_req;
    logic [c_num_lines-1:0] w_w1c;
    logic [c_num_lines-1:0] w_fire_clr;
    logic                   w_sel_valid;
    logic [c_id_w-1:0]      w_sel_id;
    logic [c_id_w-1:0]      w_last_id;
    logic                   w_fire_go;
    logic                   w_eoi;

    assign w_off    = usermem_address - BASE;
    assign irqc_hit = (w_off < 8'd4);
    assign w_wr     = rw & irqc_hit;

    assign w_rise     = irq_in & ~r_irq_prev;
    assign w_req      = r_pending & r_mask[c_num_lines-1:0];
    assign w_w1c      = (w_wr && w_off[1:0] == c_off_pending) ? usermem_data_out[c_num_lines-1:0] : '0;
    assign w_fire_clr = (r_state == c_st_fire) ? (c_num_lines'(1) << r_sel_id) : '0;
    assign w_fire_go  = (r_state == c_st_idle) && w_sel_valid && !pc_freeze;
    assign w_eoi      = w_wr && (w_off[1:0] == c_off_eoi);

    // r_sel_id doubles as "last served id"; its reset value 3 starts the scan at 0.
`ifdef IRQC_ROUND_ROBIN_EN
    assign w_last_id = r_sel_id;
`else
    assign w_last_id = 2'd3;
`endif

    irq_prio_sel u_sel (
        .i_req     (w_req),
        .i_last_id (w_last_id),
        .o_valid   (w_sel_valid),
        .o_id      (w_sel_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask       <= '0;
            r_pending    <= '0;
            r_irq_prev   <= '0;
            r_state      <= c_st_idle;
            r_in_service <= 1'b0;
            r_cause_id   <= '0;
            r_sel_id     <= 2'd3;
        end else begin
            r_irq_prev <= irq_in;
            // Rising edges are OR-ed in last so a same-cycle clear never loses them.
            r_pending  <= (r_pending & ~w_w1c & ~w_fire_clr) | w_rise;
            if (w_wr && w_off[1:0] == c_off_mask) begin
                r_mask <= usermem_data_out;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_fire_go) begin
                        r_sel_id <= w_sel_id;
                        r_state  <= c_st_fire;
                    end
                end
                c_st_fire: begin
                    r_cause_id   <= r_sel_id;
                    r_in_service <= 1'b1;
                    r_state      <= c_st_service;
                end
                c_st_service: begin
                    if (w_eoi) begin
                        r_in_service <= 1'b0;
                        r_state      <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign interrupt = (r_state == c_st_fire) && !reset;

    always_comb begin
        irqc_rdata = 8'h00;
        if (irqc_hit) begin
            case (w_off[1:0])
                c_off_mask:    irqc_rdata = r_mask;
                c_off_pending: irqc_rdata = {4'b0000, r_pending};
                c_off_cause:   irqc_rdata = {r_in_service, 5'b00000, r_cause_id};
                default:       irqc_rdata = 8'h00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
//==============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_irq_controller;

    localparam logic [7:0] c_base = 8'hF8;
    localparam logic [1:0] c_mask = 2'd0;
    localparam logic [1:0] c_pend = 2'd1;
    localparam logic [1:0] c_caus = 2'd2;
    localparam logic [1:0] c_eoi  = 2'd3;

`ifdef IRQC_ROUND_ROBIN_EN
    localparam logic [7:0] c_pair_first  = 8'h83;
    localparam logic [7:0] c_pair_second = 8'h81;
`else
    localparam logic [7:0] c_pair_first  = 8'h81;
    localparam logic [7:0] c_pair_second = 8'h83;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_in = 4'h0;
    logic       rw = 1'b0;
    logic [7:0] usermem_address = 8'h00;
    logic [7:0] usermem_data_out = 8'h00;
    logic       pc_freeze = 1'b0;
    logic       interrupt;
    logic       irqc_hit;
    logic [7:0] irqc_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(.BASE(c_base)) dut (
        .clk              (clk),
        .reset            (reset),
        .irq_in           (irq_in),
        .rw               (rw),
        .usermem_address  (usermem_address),
        .usermem_data_out (usermem_data_out),
        .pc_freeze        (pc_freeze),
        .interrupt        (interrupt),
        .irqc_hit         (irqc_hit),
        .irqc_rdata       (irqc_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        usermem_address  = c_base + {6'b0, off};
        usermem_data_out = d;
        rw = 1'b1;
        tick();
        rw = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [7:0] exp);
        usermem_address = c_base + {6'b0, off};
        #1;
        check(tag, irqc_rdata, exp);
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_in = v;
        tick();
        irq_in = 4'h0;
    endtask

    // Called one cycle before the expected FIRE cycle.
    task automatic serve(input string tag, input logic [7:0] exp_cause);
        check({tag, "_pre"}, 8'(interrupt), 8'h00);
        tick();
        check({tag, "_fire"}, 8'(interrupt), 8'h01);
        tick();
        check({tag, "_post"}, 8'(interrupt), 8'h00);
        chk_reg({tag, "_cause"}, c_caus, exp_cause);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("irq_in_reset", 8'(interrupt), 8'h00);
        reset = 1'b0;
        check("irq_after_reset", 8'(interrupt), 8'h00);
        chk_reg("rst_mask", c_mask, 8'h00);
        chk_reg("rst_pend", c_pend, 8'h00);
        chk_reg("rst_cause", c_caus, 8'h00);

        usermem_address = 8'hF7;
        #1;
        check("hit_below", 8'(irqc_hit), 8'h00);
        check("rdata_nohit", irqc_rdata, 8'h00);
        usermem_address = 8'hFB;
        #1;
        check("hit_top", 8'(irqc_hit), 8'h01);

        wr(c_mask, 8'h0F);
        chk_reg("mask_rb", c_mask, 8'h0F);
        usermem_address  = 8'hF7;
        usermem_data_out = 8'h00;
        rw = 1'b1;
        tick();
        rw = 1'b0;
        chk_reg("mask_nohit_wr", c_mask, 8'h0F);

        // Single edge on line 2
        pulse(4'b0100);
        serve("l2", 8'h82);
        chk_reg("l2_pend", c_pend, 8'h00);

        // Edge during SERVICE waits for EOI
        pulse(4'b0001);
        tick();
        tick();
        check("svc_hold", 8'(interrupt), 8'h00);
        chk_reg("svc_pend", c_pend, 8'h01);
        wr(c_eoi, 8'h00);
        serve("l0", 8'h80);

        // Arbitration between lines 1 and 3 after serving line 1
        wr(c_eoi, 8'h00);
        pulse(4'b0010);
        serve("l1", 8'h81);
        wr(c_eoi, 8'h00);
        pulse(4'b1010);
        serve("pair1", c_pair_first);
        wr(c_eoi, 8'h00);
        serve("pair2", c_pair_second);

        // pc_freeze hold-off
        wr(c_eoi, 8'h00);
        pc_freeze = 1'b1;
        pulse(4'b0100);
        check("frz_b", 8'(interrupt), 8'h00);
        tick();
        check("frz_c", 8'(interrupt), 8'h00);
        tick();
        pc_freeze = 1'b0;
        check("frz_d", 8'(interrupt), 8'h00);
        tick();
        check("frz_fire", 8'(interrupt), 8'h01);
        tick();
        chk_reg("frz_cause", c_caus, 8'h82);

        // Edge and W1C on the same bit: set wins
        wr(c_eoi, 8'h00);
        wr(c_mask, 8'h00);
        irq_in           = 4'b0001;
        usermem_address  = c_base + 8'd1;
        usermem_data_out = 8'h01;
        rw = 1'b1;
        tick();
        rw = 1'b0;
        irq_in = 4'h0;
        chk_reg("setwins_pend", c_pend, 8'h01);
        tick();
        tick();
        check("masked_noirq", 8'(interrupt), 8'h00);
        chk_reg("masked_pend", c_pend, 8'h01);
        wr(c_pend, 8'h01);
        chk_reg("w1c_pend", c_pend, 8'h00);

        // Reset while in SERVICE
        wr(c_mask, 8'h0F);
        pulse(4'b0010);
        serve("pre_rst", 8'h81);
        reset = 1'b1;
        tick();
        check("svc_rst_irq", 8'(interrupt), 8'h00);
        reset = 1'b0;
        check("svc_rst_after", 8'(interrupt), 8'h00);
        chk_reg("svc_rst_cause", c_caus, 8'h00);
        chk_reg("svc_rst_mask", c_mask, 8'h00);
        chk_reg("svc_rst_pend", c_pend, 8'h00);
        pulse(4'b0001);
        tick();
        tick();
        check("rst_masked_noirq", 8'(interrupt), 8'h00);
        chk_reg("rst_masked_pend", c_pend, 8'h01);
        wr(c_mask, 8'h0F);
        serve("rst_idle", 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter BASE, default 8'hF8, user-memory base address of the 4-byte register window (BASE..BASE+3).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port irq_in  input  4  peripheral interrupt lines, rising-edge triggered, already synchronous to clk.
REQ-005 SHALL have port rw  input  1  CPU user-memory write strobe, 1 = write.
REQ-006 SHALL have port usermem_address  input  8  CPU user-memory address.
REQ-007 SHALL have port usermem_data_out  input  8  CPU user-memory write data.
REQ-008 SHALL have port pc_freeze  input  1  CPU is in a multi-cycle stage; interrupts are withheld while 1.
REQ-009 SHALL have port interrupt  output  1  one-cycle request pulse to the CPU control unit.
REQ-010 SHALL have port irqc_hit  output  1  usermem_address is within the register window.
REQ-011 SHALL have port irqc_rdata  output  8  combinational register read data; 0 when irqc_hit=0.

Function
REQ-012 SHALL map registers: BASE+0 MASK (RW, bit n=1 enables line n); BASE+1 PENDING (read; write-1-to-clear); BASE+2 CAUSE (RO: bit7 in-service, bits1:0 line id, others 0); BASE+3 EOI (write any value).
REQ-013 SHALL register irq_in each cycle and set PENDING[n] on a 0->1 transition of the registered versus the current value.
REQ-014 SHALL treat a rising edge and a W1C on the same bit in the same cycle as set (set wins).
REQ-015 SHALL implement FSM IDLE, FIRE, SERVICE.
REQ-016 IDLE->FIRE when (PENDING & MASK)!=0 and pc_freeze=0; otherwise remain in IDLE.
REQ-017 FIRE: interrupt=1 for exactly this cycle; load CAUSE id with the selected line and set CAUSE[7]; clear the selected PENDING bit; next state SERVICE.
REQ-018 SHALL select the line during the IDLE->FIRE transition cycle using MASK and PENDING as they were before any same-cycle write.
REQ-019 SERVICE->IDLE on a write to BASE+3, clearing CAUSE[7]; CAUSE id SHALL be retained; EOI writes in IDLE or FIRE SHALL be ignored.
REQ-020 New edges in FIRE or SERVICE SHALL accumulate in PENDING; there is no nesting.
REQ-021 interrupt SHALL be 0 in every state other than FIRE and SHALL never be 1 during or in the cycle after reset.
REQ-022 Writes SHALL take effect only when rw=1 and irqc_hit=1; reads SHALL have zero-cycle latency.

Reset
REQ-023 Reset SHALL set MASK=0, PENDING=0, CAUSE=0, edge register=0 and state=IDLE, and SHALL drive interrupt=0.
REQ-024 Reset asserted in FIRE or SERVICE SHALL abandon the in-service interrupt without any EOI.

Configuration
REQ-025 With macro IRQC_ROUND_ROBIN_EN defined, the arbiter SHALL use round-robin selection starting from (last served id + 1) mod 4, where the last served id resets to 3.
REQ-026 Without IRQC_ROUND_ROBIN_EN, the arbiter SHALL use fixed priority, with the lowest index having the highest priority.

Structure
REQ-027 A shared package SHALL hold the register offsets (MASK/PENDING/CAUSE/EOI), the FSM state encoding, and the line count of 4.
REQ-028 The selector SHALL be a sub-module irq_prio_sel (inputs: request vector, last id; outputs: valid, id).

Verification
REQ-029 After reset, write MASK=8'h0F, pulse irq_in[2] -> one interrupt pulse two cycles later; CAUSE reads 8'h82; PENDING reads 0.
REQ-030 In SERVICE, pulse irq_in[0] -> no interrupt until the EOI write; after EOI, interrupt pulses and CAUSE reads 8'h80.
REQ-031 Raise irq_in[1] and irq_in[3] together with MASK=0F -> fixed priority: id 1 then id 3; with IRQC_ROUND_ROBIN_EN after a prior id 1, the same edges are served as id 3 then id 1.
REQ-032 Pending line with pc_freeze=1 for 3 cycles -> interrupt is held off and fires on the first cycle after pc_freeze falls.
REQ-033 Edge on line 0 in the same cycle as a W1C to PENDING of 8'h01 -> PENDING reads 8'h01; MASK=0 leaves PENDING 8'h01 with no interrupt.
REQ-034 Assert reset during SERVICE -> CAUSE=0, MASK=0, interrupt stays 0; a subsequent edge with MASK=0 produces no interrupt.
